// File: rtl/fifo_drain_skid.sv
// Two-entry skid buffer draining an upstream FIFO: pops are decided from registered
// state only, so out_ready never reaches fifo_pop combinationally.
module fifo_drain_skid #(
  parameter int DATA_WIDTH  = 70,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fifo_valid,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  output logic                   fifo_pop,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  input  logic                   out_ready,
  input  logic                   flush,
  output logic [1:0]             occupancy,
  output logic [COUNT_WIDTH-1:0] pop_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e                 state_q;
  logic [DATA_WIDTH-1:0]  head_q;
  logic [DATA_WIDTH-1:0]  tail_q;
  logic [COUNT_WIDTH-1:0] pop_count_q;
  logic [COUNT_WIDTH-1:0] pop_count_d;
  logic                   pop_en;
  logic                   accept;

  // pop_en drives the flops; rst_n only gates the port so it stays low during reset
  assign pop_en    = fifo_valid & ~flush & (state_q != TWO);
  assign fifo_pop  = pop_en & rst_n;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = head_q;
  assign occupancy = state_q;
  assign accept    = out_valid & out_ready;
  assign pop_count = pop_count_q;

  assign pop_count_d = pop_count_q + COUNT_WIDTH'(pop_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (pop_en) begin
            state_q <= ONE;
            head_q  <= fifo_data;
          end
        end
        ONE: begin
          if (pop_en && accept) begin
            head_q <= fifo_data;
          end else if (pop_en) begin
            state_q <= TWO;
            tail_q  <= fifo_data;
          end else if (accept) begin
            state_q <= EMPTY;
          end
        end
        TWO: begin
          if (accept) begin
            state_q <= ONE;
            head_q  <= tail_q;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_count_q <= '0;
    end else begin
      pop_count_q <= pop_count_d;
    end
  end

endmodule

// File: tb/tb_fifo_drain_skid.sv
// Directed bench for fifo_drain_skid; upstream FIFO presents 0xA + index as its head entry.
module tb_fifo_drain_skid;
  localparam int DW = 70;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          fifo_valid;
  logic [DW-1:0] fifo_data;
  logic          fifo_pop;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          flush;
  logic [1:0]    occupancy;
  logic [CW-1:0] pop_count;

  int compares = 0;
  int fails    = 0;
  int src_idx  = 0;
  int src_lim  = 0;
  logic pop_seen;

  fifo_drain_skid #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_valid(fifo_valid), .fifo_data(fifo_data),
    .fifo_pop(fifo_pop), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .flush(flush), .occupancy(occupancy), .pop_count(pop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_src();
    fifo_data  = DW'(10 + src_idx);
    fifo_valid = (src_idx < src_lim);
  endtask

  // One clock: sample the pop strobe mid-cycle, take the edge, then advance the upstream FIFO.
  task automatic tick();
    @(negedge clk);
    pop_seen = fifo_pop;
    @(posedge clk);
    #1;
    if (pop_seen) src_idx++;
    drive_src();
  endtask

  task automatic reset_dut();
    rst_n     = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    src_idx   = 0;
    src_lim   = 0;
    drive_src();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1; flush = 1'b0;
    src_idx = 0; src_lim = 4; drive_src();
    @(posedge clk); #1;
    compares++; if (fifo_pop !== 1'b0) begin fails++; $display("FAIL reset_pop got %b want 0", fifo_pop); end
    compares++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", out_valid); end
    compares++; if (occupancy !== 2'd0) begin fails++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    compares++; if (pop_count !== 4'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", pop_count); end
    compares++; if (out_data !== '0) begin fails++; $display("FAIL reset_data got %h want 0", out_data); end
    #3 rst_n = 1'b1;
    #1;
    compares++; if (fifo_pop !== 1'b1) begin fails++; $display("FAIL release_pop got %b want 1", fifo_pop); end
    compares++; if (pop_count !== 4'd0) begin fails++; $display("FAIL release_cnt got %0d want 0", pop_count); end
  endtask

  task automatic test_stream();
    reset_dut();
    src_lim = 3; out_ready = 1'b1; drive_src();
    for (int k = 0; k < 3; k++) begin
      tick();
      compares++; if (out_valid !== 1'b1) begin fails++; $display("FAIL stream_valid%0d got %b want 1", k, out_valid); end
      compares++; if (out_data !== DW'(10 + k)) begin fails++; $display("FAIL stream_data%0d got %h want %h", k, out_data, DW'(10 + k)); end
    end
    tick();
    compares++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_drained got %b want 0", out_valid); end
    compares++; if (pop_count !== 4'd3) begin fails++; $display("FAIL stream_cnt got %0d want 3", pop_count); end
  endtask

  task automatic test_backpressure();
    reset_dut();
    src_lim = 8; out_ready = 1'b0; drive_src();
    repeat (4) tick();
    compares++; if (occupancy !== 2'd2) begin fails++; $display("FAIL bp_occ got %0d want 2", occupancy); end
    compares++; if (pop_count !== 4'd2) begin fails++; $display("FAIL bp_cnt got %0d want 2", pop_count); end
    compares++; if (fifo_pop !== 1'b0) begin fails++; $display("FAIL bp_pop got %b want 0", fifo_pop); end
    compares++; if (out_data !== DW'(10)) begin fails++; $display("FAIL bp_head got %h want a", out_data); end
    out_ready = 1'b1;
    tick();
    compares++; if (out_data !== DW'(11)) begin fails++; $display("FAIL bp_second got %h want b", out_data); end
    compares++; if (occupancy !== 2'd1) begin fails++; $display("FAIL bp_occ1 got %0d want 1", occupancy); end
    compares++; if (fifo_pop !== 1'b1) begin fails++; $display("FAIL bp_resume got %b want 1", fifo_pop); end
    tick();
    compares++; if (out_data !== DW'(12)) begin fails++; $display("FAIL bp_third got %h want c", out_data); end
    compares++; if (pop_count !== 4'd3) begin fails++; $display("FAIL bp_cnt3 got %0d want 3", pop_count); end
  endtask

  task automatic test_pop_accept();
    reset_dut();
    src_lim = 8; out_ready = 1'b0; drive_src();
    tick();
    compares++; if (occupancy !== 2'd1) begin fails++; $display("FAIL pa_occ_a got %0d want 1", occupancy); end
    out_ready = 1'b1;
    tick();
    compares++; if (occupancy !== 2'd1) begin fails++; $display("FAIL pa_occ_b got %0d want 1", occupancy); end
    compares++; if (out_data !== DW'(11)) begin fails++; $display("FAIL pa_data_b got %h want b", out_data); end
    tick();
    compares++; if (out_data !== DW'(12)) begin fails++; $display("FAIL pa_data_c got %h want c", out_data); end
  endtask

  task automatic test_flush();
    reset_dut();
    src_lim = 8; out_ready = 1'b0; drive_src();
    repeat (2) tick();
    compares++; if (occupancy !== 2'd2) begin fails++; $display("FAIL fl_occ2 got %0d want 2", occupancy); end
    flush = 1'b1; out_ready = 1'b1;
    #1;
    compares++; if (fifo_pop !== 1'b0) begin fails++; $display("FAIL fl_pop2 got %b want 0", fifo_pop); end
    tick();
    flush = 1'b0; out_ready = 1'b0;
    #1;
    compares++; if (occupancy !== 2'd0) begin fails++; $display("FAIL fl_occ0 got %0d want 0", occupancy); end
    compares++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fl_valid got %b want 0", out_valid); end
    compares++; if (pop_count !== 4'd2) begin fails++; $display("FAIL fl_cnt got %0d want 2", pop_count); end
    compares++; if (fifo_pop !== 1'b1) begin fails++; $display("FAIL fl_resume got %b want 1", fifo_pop); end
    tick();
    compares++; if (out_data !== DW'(12)) begin fails++; $display("FAIL fl_next got %h want c", out_data); end
    flush = 1'b1;
    #1;
    compares++; if (fifo_pop !== 1'b0) begin fails++; $display("FAIL fl_pop1 got %b want 0", fifo_pop); end
    tick();
    flush = 1'b0;
    compares++; if (occupancy !== 2'd0) begin fails++; $display("FAIL fl_occ_one got %0d want 0", occupancy); end
    compares++; if (pop_count !== 4'd3) begin fails++; $display("FAIL fl_cnt3 got %0d want 3", pop_count); end
  endtask

  task automatic test_wrap();
    reset_dut();
    src_lim = 100; out_ready = 1'b1; drive_src();
    repeat (17) tick();
    compares++; if (pop_count !== 4'd1) begin fails++; $display("FAIL wrap_cnt got %0d want 1", pop_count); end
    compares++; if (out_data !== DW'(26)) begin fails++; $display("FAIL wrap_data got %h want %h", out_data, DW'(26)); end
  endtask

  task automatic test_async_reset();
    reset_dut();
    src_lim = 8; out_ready = 1'b0; drive_src();
    repeat (2) tick();
    compares++; if (occupancy !== 2'd2) begin fails++; $display("FAIL ar_pre got %0d want 2", occupancy); end
    #2 rst_n = 1'b0;
    #1;
    compares++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ar_valid got %b want 0", out_valid); end
    compares++; if (occupancy !== 2'd0) begin fails++; $display("FAIL ar_occ got %0d want 0", occupancy); end
    compares++; if (pop_count !== 4'd0) begin fails++; $display("FAIL ar_cnt got %0d want 0", pop_count); end
    compares++; if (fifo_pop !== 1'b0) begin fails++; $display("FAIL ar_pop got %b want 0", fifo_pop); end
    @(posedge clk); #1;
    compares++; if (pop_count !== 4'd0) begin fails++; $display("FAIL ar_hold got %0d want 0", pop_count); end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_pop_accept();
    test_flush();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
